// File: rtl/button_input_conditioner.sv
// Per-button 2-FF sync, counter debounce and registered press/release pulses; level/pulse land E+1+DEBOUNCE_CYCLES after sync1 capture.
// No backpressure: pulses are single-cycle and unbuffered; chip_select high idles counters and suppresses pulses.
module button_input_conditioner #(
   parameter int NUM_BTN         = 4,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               chip_select,
   input  logic [NUM_BTN-1:0] button_raw,
   output logic [NUM_BTN-1:0] button_level,
   output logic [NUM_BTN-1:0] button_press,
   output logic [NUM_BTN-1:0] button_release,
   output logic               any_press
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_BTN-1:0]            sync1_q, sync2_q;
   logic [NUM_BTN-1:0]            level_q, level_d;
   logic [NUM_BTN-1:0]            press_q, press_d;
   logic [NUM_BTN-1:0]            release_q, release_d;
   logic                          any_press_q, any_press_d;
   logic [NUM_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      level_d   = level_q;
      press_d   = '0;
      release_d = '0;
      cnt_d     = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         // Counter only advances while selected and the synced input disagrees with the accepted level.
         if (!chip_select && (sync2_q[i] != level_q[i])) begin
            if (cnt_q[i] == CNT_LAST) begin
               level_d[i]   = sync2_q[i];
               press_d[i]   = sync2_q[i];
               release_d[i] = ~sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
      any_press_d = |press_d;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         level_q     <= '0;
         press_q     <= '0;
         release_q   <= '0;
         any_press_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         sync1_q     <= button_raw;
         sync2_q     <= sync1_q;
         level_q     <= level_d;
         press_q     <= press_d;
         release_q   <= release_d;
         any_press_q <= any_press_d;
         cnt_q       <= cnt_d;
      end
   end

   assign button_level   = level_q;
   assign button_press   = press_q;
   assign button_release = release_q;
   assign any_press      = any_press_q;

endmodule

// File: tb/tb_button_input_conditioner.sv
// Directed bench for button_input_conditioner with DEBOUNCE_CYCLES=4: vector table plus hand sequences.
module tb_button_input_conditioner;

   localparam int NB = 4;

   logic          clk = 1'b0;
   logic          n_rst;
   logic          chip_select;
   logic [NB-1:0] button_raw;
   logic [NB-1:0] button_level, button_press, button_release;
   logic          any_press;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [NB-1:0] raw;
      logic          cs;
      logic [NB-1:0] lvl;
      logic [NB-1:0] pr;
      logic [NB-1:0] rl;
      logic          any;
   } vec_t;

   vec_t vecs[$];

   button_input_conditioner #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(4)) dut (
      .clk            (clk),
      .n_rst          (n_rst),
      .chip_select    (chip_select),
      .button_raw     (button_raw),
      .button_level   (button_level),
      .button_press   (button_press),
      .button_release (button_release),
      .any_press      (any_press)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   task automatic add_n(input int n, input logic [NB-1:0] raw, input logic cs,
                        input logic [NB-1:0] lvl, input logic [NB-1:0] pr,
                        input logic [NB-1:0] rl, input logic any);
      vec_t v;
      v.raw = raw; v.cs = cs; v.lvl = lvl; v.pr = pr; v.rl = rl; v.any = any;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [3*NB:0] exp);
      logic [3*NB:0] act;
      act = {button_level, button_press, button_release, any_press};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got lvl/press/rel/any=%b required %b", name, act, exp);
      end
   endtask

   task automatic run_n(input string name, input int n, input logic [3*NB:0] exp);
      for (int k = 0; k < n; k++) begin
         step();
         check($sformatf("%s_%0d", name, k), exp);
      end
   endtask

   initial begin
      // Test 1: idle after reset
      add_n(20, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      // Test 2: single press on channel 0, then release
      add_n(5,  4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      add_n(1,  4'b0001, 1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1);
      add_n(1,  4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0);
      add_n(5,  4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0);
      add_n(1,  4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0);
      add_n(1,  4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      // Test 4: three channels step together
      add_n(5,  4'b1011, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      add_n(1,  4'b1011, 1'b0, 4'b1011, 4'b1011, 4'b0000, 1'b1);
      add_n(1,  4'b1011, 1'b0, 4'b1011, 4'b0000, 4'b0000, 1'b0);
      add_n(5,  4'b0000, 1'b0, 4'b1011, 4'b0000, 4'b0000, 1'b0);
      add_n(1,  4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1011, 1'b0);
      add_n(1,  4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);

      n_rst       = 1'b1;
      chip_select = 1'b0;
      button_raw  = '0;
      #2 n_rst = 1'b0;
      #1 check("reset_state", '0);
      step();
      step();
      n_rst = 1'b1;

      foreach (vecs[i]) begin
         button_raw  = vecs[i].raw;
         chip_select = vecs[i].cs;
         step();
         check($sformatf("vec%0d", i), {vecs[i].lvl, vecs[i].pr, vecs[i].rl, vecs[i].any});
      end

      // Test 3: bouncing channel 2 never accepted
      for (int k = 0; k < 12; k++) begin
         button_raw = (k % 2 == 0) ? 4'b0100 : 4'b0000;
         step();
         check($sformatf("bounce_%0d", k), '0);
      end
      button_raw = 4'b0000;
      run_n("bounce_settle", 6, '0);

      // Test 5: change while deselected, accepted DEBOUNCE_CYCLES after reselect
      chip_select = 1'b1;
      button_raw  = 4'b0010;
      run_n("desel", 10, '0);
      chip_select = 1'b0;
      run_n("resel_wait", 3, '0);
      run_n("resel_press", 1, {4'b0010, 4'b0010, 4'b0000, 1'b1});
      run_n("resel_hold", 1, {4'b0010, 4'b0000, 4'b0000, 1'b0});
      button_raw = 4'b0000;
      run_n("resel_rel_wait", 5, {4'b0010, 4'b0000, 4'b0000, 1'b0});
      run_n("resel_rel", 1, {4'b0000, 4'b0000, 4'b0010, 1'b0});
      run_n("resel_idle", 1, '0);

      // Deselect on the cycle the accept would fire, then full restart
      button_raw = 4'b0010;
      run_n("cs_edge_pend", 5, '0);
      chip_select = 1'b1;
      run_n("cs_edge_supp", 3, '0);
      chip_select = 1'b0;
      run_n("cs_edge_restart", 3, '0);
      run_n("cs_edge_press", 1, {4'b0010, 4'b0010, 4'b0000, 1'b1});
      button_raw = 4'b0000;
      run_n("cs_edge_rel_wait", 5, {4'b0010, 4'b0000, 4'b0000, 1'b0});
      run_n("cs_edge_rel", 1, {4'b0000, 4'b0000, 4'b0010, 1'b0});

      // Test 6: reset in the middle of a pending press
      button_raw = 4'b1000;
      run_n("pre_rst_wait", 5, '0);
      run_n("pre_rst_press", 1, {4'b1000, 4'b1000, 4'b0000, 1'b1});
      button_raw = 4'b1001;
      run_n("pend_cnt", 4, {4'b1000, 4'b0000, 4'b0000, 1'b0});
      n_rst = 1'b0;
      #1 check("rst_mid_count", '0);
      step();
      step();
      n_rst = 1'b1;
      run_n("post_rst_wait", 5, '0);
      run_n("post_rst_press", 1, {4'b1001, 4'b1001, 4'b0000, 1'b1});
      run_n("post_rst_hold", 1, {4'b1001, 4'b0000, 4'b0000, 1'b0});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
